// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush controller for a 5-stage pipeline
//            (IF_ID, ID_EXE, EXE_MEM, MEM_WB pipeline registers).
//            - Detects load-use hazards between EXE and ID.
//            - Applies branch redirects resolved in MEM.
//            - Sequences multi-cycle data-memory accesses through a
//              req/ack handshake with a timeout that traps into ERR.
//            - Keeps saturating stall / flush performance counters.
// Ports    :
//   clk, rst                  clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt  source operands of the instruction in ID
//   ex_mem_to_reg, ex_dest    load flag / destination of the EXE instruction
//   mem_branch, mem_zero      branch resolution from EXE_MEM
//   mem_read, mem_write       MEM-stage data-memory access
//   dmem_ack                  data memory completes the access this cycle
//   dmem_req                  data memory request
//   pc_write, pc_src          PC enable, PC source (1 = branch target)
//   *_en / *_flush            pipeline register load enables / bubble loads
//   timeout_err               sticky memory-timeout flag
//   stall_cnt, flush_cnt      saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int WAIT_W  = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_to_reg,
   input  logic [4:0]       ex_dest,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_write,
   output logic             pc_src,
   output logic             if_id_en,
   output logic             id_exe_en,
   output logic             exe_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             exe_mem_flush,
   output logic             mem_wb_flush,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

   localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

   state_t              r_state;
   state_t              w_state_next;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_next;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;
   logic                r_timeout_err;

   logic w_mem_access;
   logic w_hazard;
   logic w_freeze;
   logic w_active;
   logic w_branch_taken;
   logic w_load_use;

   assign w_mem_access = mem_read | mem_write;

   // The EXE load result is not available until after MEM; a dependent ID
   // instruction must wait one cycle. Register 0 is hard-wired, never a hazard.
   assign w_hazard = ex_mem_to_reg & (ex_dest != 5'd0) &
                     ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

   // Freeze: the MEM access has not completed, so everything upstream holds
   // and MEM_WB receives a bubble. Hazards are only evaluated when not frozen.
   assign w_freeze = ((r_state == ST_RUN)      & w_mem_access & ~dmem_ack) |
                     ((r_state == ST_MEM_WAIT) & ~dmem_ack);
   assign w_active = ((r_state == ST_RUN)      & ~w_freeze) |
                     ((r_state == ST_MEM_WAIT) & dmem_ack);

   // A taken branch squashes the ID instruction, so it overrides a load-use stall.
   assign w_branch_taken = w_active & mem_branch & mem_zero;
   assign w_load_use     = w_active & ~w_branch_taken & w_hazard;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and pipeline control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_wait_next   = r_wait_cnt;
      dmem_req      = w_mem_access;
      pc_write      = 1'b1;
      pc_src        = 1'b0;
      if_id_en      = 1'b1;
      id_exe_en     = 1'b1;
      exe_mem_en    = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_flush = 1'b0;
      mem_wb_flush  = 1'b0;

      if (r_state == ST_ERR) begin
         // Trapped: the pipeline is fully frozen until reset.
         dmem_req   = 1'b0;
         pc_write   = 1'b0;
         if_id_en   = 1'b0;
         id_exe_en  = 1'b0;
         exe_mem_en = 1'b0;
         mem_wb_en  = 1'b0;
      end else if (w_freeze) begin
         pc_write     = 1'b0;
         if_id_en     = 1'b0;
         id_exe_en    = 1'b0;
         exe_mem_en   = 1'b0;
         mem_wb_flush = 1'b1;
         // Wait counter holds the number of frozen cycles including this one.
         w_wait_next  = (r_state == ST_RUN) ? WAIT_W'(1) : r_wait_cnt + WAIT_W'(1);
         w_state_next = (w_wait_next == C_TIMEOUT) ? ST_ERR : ST_MEM_WAIT;
      end else begin
         w_state_next = ST_RUN;
         w_wait_next  = '0;
         if (w_branch_taken) begin
            pc_src        = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
         end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
         end
      end

      // While reset is held every register loads a bubble and the PC holds.
      if (rst) begin
         dmem_req      = 1'b0;
         pc_write      = 1'b0;
         pc_src        = 1'b0;
         if_id_en      = 1'b1;
         id_exe_en     = 1'b1;
         exe_mem_en    = 1'b1;
         mem_wb_en     = 1'b1;
         if_id_flush   = 1'b1;
         id_exe_flush  = 1'b1;
         exe_mem_flush = 1'b1;
         mem_wb_flush  = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky timeout flag and saturating performance counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeout_err <= 1'b0;
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
      end else begin
         if (w_state_next == ST_ERR) begin
            r_timeout_err <= 1'b1;
         end
         if ((w_freeze | w_load_use) && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_branch_taken && (r_flush_cnt != C_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign timeout_err = r_timeout_err;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//            model (plain integers for mode, wait length and counters) gives
//            the expected control word every cycle; directed steps also pin
//            selected cycles to hand-computed literal values. Counters are
//            narrowed to 4 bits so saturation is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int TIMEOUT = 15;
   localparam int WAIT_W  = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // Control word: {pc_write, pc_src, en[if_id,id_exe,exe_mem,mem_wb],
   //                flush[if_id,id_exe,exe_mem,mem_wb], dmem_req}
   localparam logic [10:0] C_RST  = 11'b0_0_1111_1111_0;
   localparam logic [10:0] C_DEF  = 11'b1_0_1111_0000_0;
   localparam logic [10:0] C_LU   = 11'b0_0_0111_0100_0;
   localparam logic [10:0] C_LUQ  = 11'b0_0_0111_0100_1;
   localparam logic [10:0] C_BR   = 11'b1_1_1111_1110_0;
   localparam logic [10:0] C_FRZ  = 11'b0_0_0001_0001_1;
   localparam logic [10:0] C_ACK  = 11'b1_0_1111_0000_1;
   localparam logic [10:0] C_ERR  = 11'b0_0_0000_0000_0;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs, id_rt, ex_dest;
   logic             id_uses_rt, ex_mem_to_reg;
   logic             mem_branch, mem_zero, mem_read, mem_write, dmem_ack;
   logic             dmem_req, pc_write, pc_src;
   logic             if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic             if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
   logic             timeout_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   // literal expectation for the current cycle
   logic        lit_valid = 1'b0;
   string       lit_name  = "";
   logic [10:0] lit_ctrl;
   int          lit_stall, lit_flush;
   logic        lit_terr;

   // model state: 0 = running, 1 = waiting on memory, 2 = trapped
   int   m_mode  = 0;
   int   m_waits = 0;
   int   m_stall = 0;
   int   m_flush = 0;
   logic m_terr  = 1'b0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .TIMEOUT (TIMEOUT),
      .WAIT_W  (WAIT_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_dest       (ex_dest),
      .mem_branch    (mem_branch),
      .mem_zero      (mem_zero),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .dmem_ack      (dmem_ack),
      .dmem_req      (dmem_req),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .if_id_en      (if_id_en),
      .id_exe_en     (id_exe_en),
      .exe_mem_en    (exe_mem_en),
      .mem_wb_en     (mem_wb_en),
      .if_id_flush   (if_id_flush),
      .id_exe_flush  (id_exe_flush),
      .exe_mem_flush (exe_mem_flush),
      .mem_wb_flush  (mem_wb_flush),
      .timeout_err   (timeout_err),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Compare process: model expectation every cycle, plus any literal pin.
   always @(negedge clk) begin : compare
      logic [10:0] act_ctrl;
      logic [10:0] e_ctrl;
      logic        stalled, taken, lu, frozen_now;
      act_ctrl = {pc_write, pc_src, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                  if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, dmem_req};
      frozen_now = 1'b0;
      lu         = 1'b0;
      taken      = 1'b0;

      if (rst) begin
         e_ctrl = C_RST;
      end else if (m_mode == 2) begin
         e_ctrl = C_ERR;
      end else begin
         stalled = !dmem_ack && ((m_mode == 1) || mem_read || mem_write);
         if (stalled) begin
            e_ctrl     = C_FRZ;
            frozen_now = 1'b1;
         end else begin
            taken = mem_branch && mem_zero;
            lu    = !taken && ex_mem_to_reg && (ex_dest != 0) &&
                    ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
            e_ctrl = taken ? C_BR : (lu ? C_LU : C_DEF);
            e_ctrl[0] = mem_read | mem_write;
         end
      end

      check("model_ctrl", 32'(act_ctrl), 32'(e_ctrl));
      check("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
      check("model_timeout_err", 32'(timeout_err), 32'(m_terr));

      if (lit_valid) begin
         check({lit_name, "_ctrl"},  32'(act_ctrl),    32'(lit_ctrl));
         check({lit_name, "_stall"}, 32'(stall_cnt),   32'(lit_stall));
         check({lit_name, "_flush"}, 32'(flush_cnt),   32'(lit_flush));
         check({lit_name, "_terr"},  32'(timeout_err), 32'(lit_terr));
      end

      // advance the model to what the next rising edge produces
      if (rst) begin
         m_mode = 0; m_waits = 0; m_stall = 0; m_flush = 0; m_terr = 1'b0;
      end else if (m_mode != 2) begin
         if (frozen_now) begin
            m_waits = m_waits + 1;
            if (m_waits >= TIMEOUT) begin
               m_mode = 2;
               m_terr = 1'b1;
            end else begin
               m_mode = 1;
            end
         end else begin
            m_mode  = 0;
            m_waits = 0;
         end
         if ((frozen_now || lu) && m_stall < CNT_MAX) m_stall = m_stall + 1;
         if (taken && m_flush < CNT_MAX) m_flush = m_flush + 1;
      end
   end

   task automatic expect_lit(input string nm, input logic [10:0] c,
                             input int s, input int f, input logic t);
      lit_name  = nm;
      lit_ctrl  = c;
      lit_stall = s;
      lit_flush = f;
      lit_terr  = t;
      lit_valid = 1'b1;
   endtask

   // One clock cycle of stimulus; inputs change 1 time unit after the edge.
   task automatic step(input logic r, input logic mtr, input logic [4:0] dest,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic zr, input logic rd,
                       input logic wr, input logic ack);
      rst = r; ex_mem_to_reg = mtr; ex_dest = dest; id_rs = rs; id_rt = rt;
      id_uses_rt = urt; mem_branch = br; mem_zero = zr; mem_read = rd;
      mem_write = wr; dmem_ack = ack;
      @(posedge clk);
      #1;
      lit_valid = 1'b0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset and idle
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_lit("reset_outputs", C_RST, 0, 0, 1'b0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_lit("idle_after_reset", C_DEF, 0, 0, 1'b0);
      idle();

      // load-use hazards
      expect_lit("load_use_rs", C_LU, 0, 0, 1'b0);
      step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      expect_lit("after_load_use", C_DEF, 1, 0, 1'b0);
      idle();
      expect_lit("load_dest_zero", C_DEF, 1, 0, 1'b0);
      step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      expect_lit("load_use_rt", C_LU, 1, 0, 1'b0);
      step(0, 1, 7, 3, 7, 1, 0, 0, 0, 0, 0);
      expect_lit("rt_not_source", C_DEF, 2, 0, 1'b0);
      step(0, 1, 7, 3, 7, 0, 0, 0, 0, 0, 0);
      step(0, 0, 5, 5, 5, 1, 0, 0, 0, 0, 0);

      // branches
      expect_lit("branch_taken", C_BR, 2, 0, 1'b0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      expect_lit("branch_not_taken", C_DEF, 2, 1, 1'b0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      expect_lit("branch_over_load_use", C_BR, 2, 1, 1'b0);
      step(0, 1, 9, 9, 0, 0, 1, 1, 0, 0, 0);
      expect_lit("after_branch_lu", C_DEF, 2, 2, 1'b0);
      idle();

      // multi-cycle load: three frozen cycles, advance on ack
      expect_lit("mem_freeze_first", C_FRZ, 2, 2, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      expect_lit("mem_freeze_third", C_FRZ, 4, 2, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      expect_lit("mem_ack_advance", C_ACK, 5, 2, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      expect_lit("after_mem", C_DEF, 5, 2, 1'b0);
      idle();
      expect_lit("mem_zero_latency", C_ACK, 5, 2, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

      // ack cycle out of MEM_WAIT still evaluates hazards
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      expect_lit("ack_cycle_load_use", C_LUQ, 6, 2, 1'b0);
      step(0, 1, 4, 4, 0, 0, 0, 0, 1, 0, 1);

      // reset in the middle of a memory wait
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      expect_lit("reset_mid_wait", C_RST, 9, 2, 1'b0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      expect_lit("idle_after_mid_reset", C_DEF, 0, 0, 1'b0);
      idle();

      // counter saturation at all-ones
      for (int i = 0; i < 17; i++) step(0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      expect_lit("stall_saturated", C_DEF, CNT_MAX, 0, 1'b0);
      idle();
      for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      expect_lit("flush_saturated", C_DEF, CNT_MAX, CNT_MAX, 1'b0);
      idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // store never acknowledged: 15 frozen cycles then ERR
      for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      expect_lit("freeze_last_before_err", C_FRZ, TIMEOUT - 1, 0, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      expect_lit("err_state", C_ERR, TIMEOUT, 0, 1'b1);
      step(0, 1, 2, 2, 0, 0, 1, 1, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      expect_lit("err_sticky", C_ERR, TIMEOUT, 0, 1'b1);
      idle();
      expect_lit("reset_clears_err", C_RST, TIMEOUT, 0, 1'b1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_lit("run_after_err_reset", C_DEF, 0, 0, 1'b0);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
